// File: rtl/stepdown_nand_deadtime.sv
// stepdown_nand_deadtime: N-input NAND command register followed by a
// dead-time / minimum-on-time FSM that produces non-overlapping high-side and
// low-side gate commands for the stepdown power stage.
// Optional feature: define STEPDOWN_DRV_FAULT_EN to add the flt input and a
// FAULT state that forces both gates low.
module stepdown_nand_deadtime #(
    parameter int unsigned N     = 3,
    parameter int unsigned DT    = 4,
    parameter int unsigned MINON = 2,
    parameter int unsigned CW    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         CELV,
    input  logic         CELG,
    input  logic         SUB,
    input  logic [N-1:0] i,
`ifdef STEPDOWN_DRV_FAULT_EN
    input  logic         flt,
`endif
    output logic         o,
    output logic         hs,
    output logic         ls,
    output logic         busy
);

    localparam logic [CW-1:0] DtLoad    = CW'(DT);
    localparam logic [CW-1:0] MinonLoad = CW'(MINON);
    localparam logic [CW-1:0] CntOne    = CW'(1);

`ifdef STEPDOWN_DRV_FAULT_EN
    typedef enum logic [1:0] {StDead, StHsOn, StLsOn, StFault} state_e;
`else
    typedef enum logic [1:0] {StDead, StHsOn, StLsOn} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          o_q;
    logic          cnt_last;

    // Power pins carry no logic; tie them off so they are visibly consumed.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    // Counter holds the cycles remaining in the current phase; the phase ends
    // on the edge where it would reach zero (or once it has saturated there).
    assign cnt_last = (cnt_q <= CntOne);

    // Command register: NAND of the drive conditions, forced to 1 in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= 1'b1;
        end else begin
            o_q <= ~&i;
        end
    end

    // Next-state and counter logic; fault (when built in) overrides all of it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StDead: begin
                // Target is taken from o in the expiry cycle only.
                if (cnt_last) begin
                    state_d = o_q ? StHsOn : StLsOn;
                    cnt_d   = MinonLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHsOn: begin
                if (cnt_last && !o_q) begin
                    state_d = StDead;
                    cnt_d   = DtLoad;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StLsOn: begin
                if (cnt_last && o_q) begin
                    state_d = StDead;
                    cnt_d   = DtLoad;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntOne;
                end
            end
`ifdef STEPDOWN_DRV_FAULT_EN
            StFault: begin
                state_d = StDead;
                cnt_d   = DtLoad;
            end
`endif
            default: begin
                state_d = StDead;
                cnt_d   = DtLoad;
            end
        endcase
`ifdef STEPDOWN_DRV_FAULT_EN
        if (flt) begin
            state_d = StFault;
            cnt_d   = DtLoad;
        end
`endif
    end

    // State and counter registers; reset restarts the full dead-time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDead;
            cnt_q   <= DtLoad;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Gate commands decode the registered state, so they can never overlap.
    always_comb begin
        o    = o_q;
        hs   = (state_q == StHsOn);
        ls   = (state_q == StLsOn);
        busy = !(hs || ls);
    end

endmodule

// File: tb/tb_stepdown_nand_deadtime.sv
// Directed bench for stepdown_nand_deadtime with default parameters
// (N=3, DT=4, MINON=2). Fault steps run when STEPDOWN_DRV_FAULT_EN is defined.
module tb_stepdown_nand_deadtime;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] i   = 3'b000;
`ifdef STEPDOWN_DRV_FAULT_EN
    logic       flt = 1'b0;
`endif
    logic       o;
    logic       hs;
    logic       ls;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stepdown_nand_deadtime #(
        .N     (3),
        .DT    (4),
        .MINON (2),
        .CW    (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .CELV (1'b1),
        .CELG (1'b0),
        .SUB  (1'b0),
        .i    (i),
`ifdef STEPDOWN_DRV_FAULT_EN
        .flt  (flt),
`endif
        .o    (o),
        .hs   (hs),
        .ls   (ls),
        .busy (busy)
    );

    // One active edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic gates(input string tag, input logic eh, input logic el, input logic eb);
        chk({tag, ".hs"}, hs, eh);
        chk({tag, ".ls"}, ls, el);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".excl"}, hs & ls, 1'b0);
    endtask

    initial begin
        // Reset with i=000: o forced to 1, both gates low.
        tick();
        tick();
        chk("rst.o", o, 1'b1);
        gates("rst", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            gates("rst_dead", 1'b0, 1'b0, 1'b1);
        end
        tick();
        gates("rst_hs", 1'b1, 1'b0, 1'b0);
        chk("rst_hs.o", o, 1'b1);

        // Let MINON expire, then swap to low side with i=111 for 10 cycles.
        tick();
        tick();
        i = 3'b111;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk("swap.o", o, 1'b0);
            gates("swap", n == 1, n >= 6, (n >= 2) && (n <= 5));
        end

        // Back to high side.
        i = 3'b000;
        tick();
        gates("back_ls", 1'b0, 1'b1, 1'b0);
        chk("back_ls.o", o, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            tick();
            gates("back_dead", 1'b0, 1'b0, 1'b1);
        end
        tick();
        gates("back_hs", 1'b1, 1'b0, 1'b0);

        // Request low side right after HS entry: held for exactly MINON cycles.
        i = 3'b111;
        tick();
        gates("minon_hold", 1'b1, 1'b0, 1'b0);
        chk("minon_hold.o", o, 1'b0);
        tick();
        gates("minon_exit", 1'b0, 1'b0, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            tick();
            gates("minon_dead", 1'b0, 1'b0, 1'b1);
        end

        // LS entry edge samples a one-cycle pulse; MINON swallows it.
        i = 3'b101;
        tick();
        gates("pulse_entry", 1'b0, 1'b1, 1'b0);
        chk("pulse_entry.o", o, 1'b1);
        i = 3'b111;
        for (int n = 1; n <= 4; n++) begin
            tick();
            gates("pulse_hold", 1'b0, 1'b1, 1'b0);
        end

        // Toggle o 1->0->1 during dead-time; HS follows after exactly DT.
        i = 3'b000;
        tick();
        gates("tog_ls", 1'b0, 1'b1, 1'b0);
        tick();
        gates("tog_dead1", 1'b0, 1'b0, 1'b1);
        i = 3'b111;
        tick();
        gates("tog_dead2", 1'b0, 1'b0, 1'b1);
        chk("tog_dead2.o", o, 1'b0);
        i = 3'b000;
        tick();
        gates("tog_dead3", 1'b0, 1'b0, 1'b1);
        chk("tog_dead3.o", o, 1'b1);
        tick();
        gates("tog_dead4", 1'b0, 1'b0, 1'b1);
        tick();
        gates("tog_hs", 1'b1, 1'b0, 1'b0);

        // Reset while hs=1, then recovery identical to power-up.
        rst = 1'b1;
        tick();
        gates("mid_rst", 1'b0, 1'b0, 1'b1);
        chk("mid_rst.o", o, 1'b1);
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            gates("mid_rst_dead", 1'b0, 1'b0, 1'b1);
        end
        tick();
        gates("mid_rst_hs", 1'b1, 1'b0, 1'b0);

`ifdef STEPDOWN_DRV_FAULT_EN
        // Reach LS, then fault while MINON is unexpired.
        i = 3'b111;
        tick();
        gates("flt_pre_hs", 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            gates("flt_pre_dead", 1'b0, 1'b0, 1'b1);
        end
        tick();
        gates("flt_pre_ls", 1'b0, 1'b1, 1'b0);
        flt = 1'b1;
        tick();
        gates("flt_on", 1'b0, 1'b0, 1'b1);
        tick();
        gates("flt_hold", 1'b0, 1'b0, 1'b1);
        flt = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            gates("flt_dead", 1'b0, 1'b0, 1'b1);
        end
        tick();
        gates("flt_ls", 1'b0, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
